fb_mem_arbiter: RTL
===================

# fb_mem_arbiter

Arbitrates a single-port synchronous framebuffer RAM between the DLX CPU data port and the VGA scanout fetcher on the DE1-SoC. VGA is a pipelined streaming port with fixed read latency. The CPU uses a req/ack handshake with one access outstanding at a time. VGA has priority, and a bounded-wait counter guarantees the CPU forward progress. The block sits between the CPU memory-mapped bus decode, the VGA pixel pipeline and the framebuffer RAM instance.

## Interface
- ADDR_W, 16, word address width
- DATA_W, 32, data width
- MAX_WAIT, 8, max consecutive cycles a requesting, eligible CPU loses to VGA; must be ≥1
- clock_50  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse (reads and writes)
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack=1; 0 otherwise
- vga_req  in  1  VGA read request, may be asserted every cycle
- vga_addr  in  ADDR_W  VGA read address, consumed when vga_req & vga_gnt
- vga_gnt  out  1  combinational grant, same cycle as vga_req
- vga_rvalid  out  1  VGA read data valid
- vga_rdata  out  DATA_W  VGA read data, valid when vga_rvalid=1; 0 otherwise
- mem_en, mem_we  out  1  registered RAM enable / write enable
- mem_addr  out  ADDR_W  registered RAM address
- mem_wdata  out  DATA_W  registered RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en
- starved  out  1  registered pulse: CPU won through the MAX_WAIT override last cycle

## Operation
- At most one RAM access is issued per cycle. The winner's access is registered onto mem_* at the end of the arbitration cycle.
- CPU eligibility: cpu_req=1 and cpu_busy=0. cpu_busy is set on a CPU grant and cleared at the end of the cycle in which cpu_ack=1. The CPU is therefore ineligible during its ack cycle, so a stale held req is never re-issued.
- Arbitration priority, highest first:
  - CPU eligible and cpu_wait==MAX_WAIT → CPU wins, vga_gnt=0.
  - vga_req=1 → VGA wins, vga_gnt=1.
  - CPU eligible → CPU wins.
  - Otherwise no access; mem_en=0 next cycle.
- cpu_wait counter, width clog2(MAX_WAIT+1):
  - increments when CPU is eligible and loses;
  - clears on a CPU grant or when cpu_req=0;
  - saturates at MAX_WAIT.
- A 2-stage tag pipeline records owner (none/VGA/CPU) and we. Stage 2 routes mem_rdata to the owner and generates cpu_ack / vga_rvalid. A CPU write acks with cpu_rdata=0. VGA never writes.
- mem_wdata=0 and mem_we=0 whenever the registered access is not a CPU write.
- Reset (asynchronous, any cycle, including mid-access): all outputs, cpu_busy, cpu_wait and the tag pipeline go to 0. Accesses in flight are dropped with no ack or rvalid after release. vga_gnt is 0 while reset_n=0.

## Timing
- Grant in cycle N → mem_* valid in N+1 → mem_rdata sampled and routed in N+2.
- VGA: vga_gnt in N, vga_rvalid/vga_rdata in N+2. Fully pipelined, one read per cycle sustained.
- CPU: granted in N, cpu_ack/cpu_rdata in N+2. Ineligible in N+1 and N+2; earliest next grant is N+3.
- Alternating VGA/CPU grants on consecutive cycles are legal. Stage-2 owners are distinct per cycle, so cpu_ack and vga_rvalid are never high in the same cycle.
- Worst-case CPU latency from req to grant with VGA saturating: MAX_WAIT cycles. Grant occurs in cycle MAX_WAIT, counting the first eligible cycle as 0.
- starved is high in N+1 for an override grant in N.

## Test plan
- CPU write addr 0x0010 data 0xDEADBEEF from idle:
  - cycle 1: mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0xDEADBEEF;
  - cycle 2: cpu_ack=1, cpu_rdata=0.
  - Follow-up read of 0x0010 returns 0xDEADBEEF with cpu_ack two cycles after its grant.
- vga_req and cpu_req both rise in cycle 0:
  - vga_gnt=1 in cycle 0; CPU granted in cycle 1 if vga_req drops, otherwise wins by override;
  - vga_rvalid in cycle 2, cpu_ack two cycles after the CPU grant;
  - never both asserted in one cycle.
- vga_req held high continuously, cpu_req raised in cycle 0 with MAX_WAIT=8:
  - vga_gnt=1 in cycles 0–7, vga_gnt=0 and CPU granted in cycle 8;
  - starved=1 in cycle 9, cpu_ack in cycle 10;
  - VGA resumes in cycle 9.
- CPU holds cpu_req high through its ack with VGA idle: grants in cycles 0, 3, 6, …; acks in cycles 2, 5, 8, … with no duplicate issue.
- VGA streams addresses 0x0100..0x0107 on consecutive cycles: vga_rvalid high for 8 consecutive cycles starting 2 cycles later, data in address order.
- reset_n pulsed low in the cycle after a CPU read grant: no cpu_ack after release, all outputs 0 during reset, a fresh cpu_req completes normally afterwards.

Source files
------------

// File: rtl/fb_mem_arbiter_if.sv
// Bundle of the CPU data port, VGA fetch port and framebuffer RAM port
// seen by fb_mem_arbiter; slave is the arbiter side, master the client side.
interface fb_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              starved;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    output cpu_ack, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, starved
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    input  cpu_ack, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, starved
  );
endinterface

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer RAM arbiter: VGA streaming reads have priority,
// the CPU req/ack port is guaranteed a grant after MAX_WAIT lost cycles.
module fb_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic           clock_50,
  input  logic           reset_n,
  fb_mem_arbiter_if.slave bus
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  logic              cpu_busy;
  logic [WAIT_W-1:0] cpu_wait;
  logic              cpu_elig;
  logic              cpu_override;
  logic              cpu_win;
  logic              vga_win;
  owner_e            owner_p1;
  owner_e            owner_p2;
  logic              we_p2;
  logic              cpu_ack_p2;
  logic              vga_vld_p2;

  // Arbitration: override beats VGA, VGA beats a normal CPU request.
  always_comb begin
    cpu_elig     = bus.cpu_req & ~cpu_busy;
    cpu_override = cpu_elig & (cpu_wait == WAIT_LIM);
    vga_win      = reset_n & bus.vga_req & ~cpu_override;
    cpu_win      = cpu_elig & (cpu_override | ~bus.vga_req);
  end

  assign bus.vga_gnt = vga_win;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.starved   <= 1'b0;
      owner_p1      <= OWN_NONE;
      owner_p2      <= OWN_NONE;
      we_p2         <= 1'b0;
      cpu_busy      <= 1'b0;
      cpu_wait      <= '0;
    end else begin
      // Stage 1: winner's access registered onto the RAM port
      bus.mem_en    <= cpu_win | vga_win;
      bus.mem_we    <= cpu_win & bus.cpu_we;
      bus.mem_addr  <= cpu_win ? bus.cpu_addr : (vga_win ? bus.vga_addr : '0);
      bus.mem_wdata <= (cpu_win & bus.cpu_we) ? bus.cpu_wdata : '0;
      bus.starved   <= cpu_win & cpu_override;
      owner_p1      <= cpu_win ? OWN_CPU : (vga_win ? OWN_VGA : OWN_NONE);

      // Stage 2: tag lines up with mem_rdata coming back from the RAM
      owner_p2      <= owner_p1;
      we_p2         <= bus.mem_we;

      // Busy spans grant through ack so a held request is not re-issued
      if (cpu_win)         cpu_busy <= 1'b1;
      else if (cpu_ack_p2) cpu_busy <= 1'b0;

      if (cpu_win || !bus.cpu_req)
        cpu_wait <= '0;
      else if (cpu_elig && (cpu_wait != WAIT_LIM))
        cpu_wait <= cpu_wait + WAIT_W'(1);
    end
  end

  assign cpu_ack_p2     = (owner_p2 == OWN_CPU);
  assign vga_vld_p2     = (owner_p2 == OWN_VGA);
  assign bus.cpu_ack    = cpu_ack_p2;
  assign bus.cpu_rdata  = (cpu_ack_p2 && !we_p2) ? bus.mem_rdata : '0;
  assign bus.vga_rvalid = vga_vld_p2;
  assign bus.vga_rdata  = vga_vld_p2 ? bus.mem_rdata : '0;

endmodule
